// File: rtl/cache_line_sequencer_if.sv
// Request, cache-array and memory-bus bundle for cache_line_sequencer.
// master is the sequencer side; slave is the cache/memory/requester side.
// Purely combinational wiring, no storage.
interface cache_line_sequencer_if #(
    parameter int LADDR_W = 15,
    parameter int DATA_W  = 16
);
    logic               req_valid;
    logic               req_ready;
    logic               req_wb;
    logic               req_fill;
    logic [LADDR_W-1:0] req_victim_addr;
    logic [LADDR_W-1:0] req_fill_addr;
    logic [2:0]         wb_idx;
    logic [DATA_W-1:0]  wb_data;
    logic [1:0]         mem_cmd;
    logic [LADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_beat;
    logic               fill_we;
    logic [2:0]         fill_idx;
    logic [DATA_W-1:0]  fill_data;
    logic               done;
    logic               err;

    modport master (
        input  req_valid, req_wb, req_fill, req_victim_addr, req_fill_addr,
               wb_data, mem_rdata, mem_beat,
        output req_ready, wb_idx, mem_cmd, mem_addr, mem_wdata,
               fill_we, fill_idx, fill_data, done, err
    );

    modport slave (
        output req_valid, req_wb, req_fill, req_victim_addr, req_fill_addr,
               wb_data, mem_rdata, mem_beat,
        input  req_ready, wb_idx, mem_cmd, mem_addr, mem_wdata,
               fill_we, fill_idx, fill_data, done, err
    );
endinterface

// File: rtl/cache_line_sequencer.sv
// Cache line writeback/fill sequencer: optional 8-beat victim writeback, then optional 8-beat line fill.
// Latency: fill-only with beats every cycle completes (done) 10 cycles after accept; writeback adds 9.
// Backpressure: req_ready only in IDLE; mem_beat paces each beat. SEQ_WATCHDOG_EN adds a stalled-beat abort.
module cache_line_sequencer #(
    parameter int BEATS   = 8,
    parameter int LADDR_W = 15,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   R_n,
    cache_line_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_CMD    = 3'd1,
        WB_DATA   = 3'd2,
        FILL_CMD  = 3'd3,
        FILL_DATA = 3'd4,
        DONE      = 3'd5
    } state_t;

    // The beat counter is a fixed 3 bits, so only 8-beat lines are supported.
    if (BEATS != 8 || TIMEOUT < 1) begin : g_param_check
        $error("cache_line_sequencer: BEATS must be 8 and TIMEOUT at least 1");
    end

    localparam logic [2:0] LAST_IDX = 3'(BEATS - 1);

    state_t             state, state_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic               wb_lat, fill_lat;
    logic [LADDR_W-1:0] victim_lat, fill_addr_lat;
    logic               accept;
    logic               timeout_hit;

    assign accept = bus.req_valid && (state == IDLE);

    // Request fields are captured once at accept and held for the whole operation.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            wb_lat        <= 1'b0;
            fill_lat      <= 1'b0;
            victim_lat    <= '0;
            fill_addr_lat <= '0;
        end else if (accept) begin
            wb_lat        <= bus.req_wb;
            fill_lat      <= bus.req_fill;
            victim_lat    <= bus.req_victim_addr;
            fill_addr_lat <= bus.req_fill_addr;
        end
    end

    // State and beat counter registers.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            in_data;

    assign in_data     = (state == WB_DATA) || (state == FILL_DATA);
    // Fires on the TIMEOUT-th consecutive beatless cycle of a data phase.
    assign timeout_hit = in_data && !bus.mem_beat && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Watchdog restarts on every beat and whenever a data phase is not active.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            wd_cnt <= '0;
        end else if (!in_data || bus.mem_beat || timeout_hit) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus.err = timeout_hit;

    // Next-state, counter and all bus outputs; outputs idle at zero outside their phase.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bus.req_ready = 1'b0;
        bus.mem_cmd   = 2'b00;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.wb_idx    = 3'd0;
        bus.fill_we   = 1'b0;
        bus.fill_idx  = 3'd0;
        bus.fill_data = '0;
        bus.done      = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (bus.req_wb)        state_nxt = WB_CMD;
                    else if (bus.req_fill) state_nxt = FILL_CMD;
                    else                   state_nxt = DONE;
                end
            end
            WB_CMD: begin
                bus.mem_cmd  = 2'b11;
                bus.mem_addr = victim_lat;
                cnt_nxt      = 3'd0;
                state_nxt    = WB_DATA;
            end
            WB_DATA: begin
                bus.wb_idx    = cnt;
                bus.mem_wdata = bus.wb_data;
                if (timeout_hit) begin
                    bus.done  = 1'b1;
                    cnt_nxt   = 3'd0;
                    state_nxt = IDLE;
                end else if (bus.mem_beat) begin
                    cnt_nxt = cnt + 3'd1;
                    if (cnt == LAST_IDX) state_nxt = fill_lat ? FILL_CMD : DONE;
                end
            end
            FILL_CMD: begin
                bus.mem_cmd  = 2'b10;
                bus.mem_addr = fill_addr_lat;
                cnt_nxt      = 3'd0;
                state_nxt    = FILL_DATA;
            end
            FILL_DATA: begin
                bus.fill_idx  = cnt;
                bus.fill_data = bus.mem_rdata;
                if (timeout_hit) begin
                    bus.done  = 1'b1;
                    cnt_nxt   = 3'd0;
                    state_nxt = IDLE;
                end else if (bus.mem_beat) begin
                    bus.fill_we = 1'b1;
                    cnt_nxt     = cnt + 3'd1;
                    if (cnt == LAST_IDX) state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_sequencer.sv
// Bench for cache_line_sequencer: transaction-level expected-event queue per request.
// Each cycle the head event (command, write beat, fill beat, done) says what the bus must show.
// Directed latency/reset/toggle cases plus randomized requests with random mem_beat.
module tb_cache_line_sequencer;

    localparam int LW = 15;
    localparam int DW = 16;
`ifdef SEQ_WATCHDOG_EN
    localparam int TMO   = 4;
    localparam bit WD_ON = 1'b1;
`else
    localparam int TMO   = 255;
    localparam bit WD_ON = 1'b0;
`endif

    localparam logic [1:0] K_CMD  = 2'd0;
    localparam logic [1:0] K_WB   = 2'd1;
    localparam logic [1:0] K_FILL = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    typedef struct packed {
        logic [1:0]    kind;
        logic [1:0]    cmd;
        logic [2:0]    idx;
        logic [LW-1:0] addr;
    } ev_t;

    logic clk = 1'b0;
    logic R_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   dc;

    logic [DW-1:0] victim_line [8];

    cache_line_sequencer_if #(.LADDR_W(LW), .DATA_W(DW)) bus ();

    cache_line_sequencer #(
        .BEATS(8), .LADDR_W(LW), .DATA_W(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .R_n(R_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Cache array read port: victim data is combinational from wb_idx.
    assign bus.wb_data = victim_line[bus.wb_idx];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Entered and left at posedge+1. mode: 0 random beats, 1 always, 2 never, 3 toggle.
    // pat: read data is beat_number*0x1111. rst_after: stop after that many fill beats (-1 none).
    task automatic run_req(input logic wb, input logic fill, input logic [LW-1:0] va,
                           input logic [LW-1:0] fa, input int mode, input bit pat,
                           input int rst_after, output int done_cyc);
        ev_t           q[$];
        ev_t           e;
        int            cyc, streak, nfill;
        logic          b, exp_err;
        logic [DW-1:0] rd, exp_fd;

        for (int i = 0; i < 8; i++) victim_line[i] = DW'($urandom);
        if (wb) begin
            q.push_back('{K_CMD, 2'b11, 3'd0, va});
            for (int i = 0; i < 8; i++) q.push_back('{K_WB, 2'b00, 3'(i), '0});
        end
        if (fill) begin
            q.push_back('{K_CMD, 2'b10, 3'd0, fa});
            for (int i = 0; i < 8; i++) q.push_back('{K_FILL, 2'b00, 3'(i), '0});
        end
        q.push_back('{K_DONE, 2'b00, 3'd0, '0});
        done_cyc = -1;

        bus.req_valid       = 1'b1;
        bus.req_wb          = wb;
        bus.req_fill        = fill;
        bus.req_victim_addr = va;
        bus.req_fill_addr   = fa;
        bus.mem_beat        = 1'($urandom);
        bus.mem_rdata       = DW'($urandom);
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        chk("fill_we_idle", 32'(bus.fill_we), 32'd0);
        @(posedge clk);
        #1;
        // Scramble request inputs: the sequencer must use the latched copy.
        bus.req_valid       = 1'b0;
        bus.req_wb          = 1'($urandom);
        bus.req_fill        = 1'($urandom);
        bus.req_victim_addr = LW'($urandom);
        bus.req_fill_addr   = LW'($urandom);

        cyc = 0; streak = 0; nfill = 0;
        while (q.size() > 0 && cyc < 200) begin
            cyc++;
            case (mode)
                1:       b = 1'b1;
                2:       b = 1'b0;
                3:       b = cyc[0];
                default: b = ($urandom_range(0, 3) != 0);
            endcase
            rd = pat ? DW'(nfill * 16'h1111) : DW'($urandom);
            bus.mem_beat  = b;
            bus.mem_rdata = rd;
            @(negedge clk);
            e = q[0];
            exp_err = WD_ON && (e.kind == K_WB || e.kind == K_FILL) && !b && (streak + 1 >= TMO);
            chk("err", 32'(bus.err), 32'(exp_err));
            case (e.kind)
                K_CMD: begin
                    chk("mem_cmd", 32'(bus.mem_cmd), 32'(e.cmd));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("fill_we_cmd", 32'(bus.fill_we), 32'd0);
                    chk("done_cmd", 32'(bus.done), 32'd0);
                    void'(q.pop_front());
                    streak = 0;
                end
                K_WB: begin
                    chk("mem_cmd_wb", 32'(bus.mem_cmd), 32'd0);
                    chk("wb_idx", 32'(bus.wb_idx), 32'(e.idx));
                    chk("mem_wdata", 32'(bus.mem_wdata), 32'(victim_line[e.idx]));
                    chk("fill_we_wb", 32'(bus.fill_we), 32'd0);
                end
                K_FILL: begin
                    chk("mem_cmd_fill", 32'(bus.mem_cmd), 32'd0);
                    chk("fill_we", 32'(bus.fill_we), 32'(b));
                    if (b) begin
                        exp_fd = pat ? DW'(32'(e.idx) * 32'h1111) : rd;
                        chk("fill_idx", 32'(bus.fill_idx), 32'(e.idx));
                        chk("fill_data", 32'(bus.fill_data), 32'(exp_fd));
                    end
                end
                default: begin
                    chk("done", 32'(bus.done), 32'd1);
                    chk("mem_cmd_done", 32'(bus.mem_cmd), 32'd0);
                    void'(q.pop_front());
                    done_cyc = cyc;
                end
            endcase
            if (e.kind == K_WB || e.kind == K_FILL) begin
                if (b) begin
                    void'(q.pop_front());
                    streak = 0;
                    if (e.kind == K_FILL) nfill++;
                    chk("done_beat", 32'(bus.done), 32'd0);
                end else if (exp_err) begin
                    chk("done_abort", 32'(bus.done), 32'd1);
                    q.delete();
                    done_cyc = cyc;
                end else begin
                    streak++;
                    chk("done_stall", 32'(bus.done), 32'd0);
                end
            end
            if (rst_after >= 0 && nfill == rst_after) break;
            @(posedge clk);
            #1;
        end
        if (rst_after < 0) chk("budget_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        bus.req_valid       = 1'b0;
        bus.req_wb          = 1'b0;
        bus.req_fill        = 1'b0;
        bus.req_victim_addr = '0;
        bus.req_fill_addr   = '0;
        bus.mem_beat        = 1'b0;
        bus.mem_rdata       = '0;
        for (int i = 0; i < 8; i++) victim_line[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mem_cmd", 32'(bus.mem_cmd), 32'd0);
        chk("rst_fill_we", 32'(bus.fill_we), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_wb_idx", 32'(bus.wb_idx), 32'd0);
        chk("rst_fill_idx", 32'(bus.fill_idx), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_fill_data", 32'(bus.fill_data), 32'd0);
        R_n = 1'b1;
        @(posedge clk);
        #1;

        run_req(1'b0, 1'b1, 15'h1234, 15'h1234, 1, 1'b1, -1, dc);
        chk("lat_fill_only", 32'(dc), 32'd10);
        run_req(1'b1, 1'b1, 15'h0042, 15'h0043, 1, 1'b0, -1, dc);
        chk("lat_wb_fill", 32'(dc), 32'd19);
        run_req(1'b1, 1'b1, 15'h0100, 15'h0200, 3, 1'b0, -1, dc);
        run_req(1'b0, 1'b0, 15'h7fff, 15'h7fff, 0, 1'b0, -1, dc);
        chk("lat_none", 32'(dc), 32'd1);

        // Reset in the middle of a fill, after beat 3 was written.
        run_req(1'b0, 1'b1, 15'h0555, 15'h0555, 1, 1'b0, 4, dc);
        @(posedge clk);
        #1;
        R_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_fill_we", 32'(bus.fill_we), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_fill_idx", 32'(bus.fill_idx), 32'd0);
        @(negedge clk);
        chk("mid_rst_done_hold", 32'(bus.done), 32'd0);
        R_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 32'(bus.done), 32'd0);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        run_req(1'b1, 1'b1, 15'h0aaa, 15'h0bbb, 1, 1'b0, -1, dc);
        chk("lat_after_rst", 32'(dc), 32'd19);

`ifdef SEQ_WATCHDOG_EN
        // Stuck memory: abort on the 4th beatless cycle of the fill phase.
        run_req(1'b0, 1'b1, 15'h0321, 15'h0321, 2, 1'b0, -1, dc);
        chk("wd_abort_cycle", 32'(dc), 32'd5);
        run_req(1'b1, 1'b0, 15'h0321, 15'h0000, 2, 1'b0, -1, dc);
        chk("wd_abort_wb_cycle", 32'(dc), 32'd5);
`endif

        for (int n = 0; n < 40; n++) begin
            run_req(1'($urandom), 1'($urandom), LW'($urandom), LW'($urandom),
                    0, 1'b0, -1, dc);
        end

        @(negedge clk);
        chk("final_ready", 32'(bus.req_ready), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
